frame_histogram: RTL and testbench

Per-frame 256-bin histogram accumulator placed directly downstream of the image filter stage. It consumes that stage's two-pixel-per-clock RGB stream, qualified by VSYNC/HSYNC. For each pixel it bins either 8-bit luma or one selected colour channel. Once a full frame has been binned, it freezes the result and exposes the 256 counts through a registered read port for the host or testbench.

---
 rtl/frame_histogram_if.sv | 36 +++
 rtl/frame_histogram.sv | 160 ++++++++++++++++
 tb/tb_frame_histogram.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_histogram_if.sv
// Pixel-pair stream, read port and status bundle for frame_histogram.
// The source/host side uses the master modport; the accumulator uses slave.
interface frame_histogram_if #(
  parameter int BIN_W = 20
);
  logic             VSYNC;
  logic             HSYNC;
  logic [7:0]       DATA_R0_IN;
  logic [7:0]       DATA_G0_IN;
  logic [7:0]       DATA_B0_IN;
  logic [7:0]       DATA_R1_IN;
  logic [7:0]       DATA_G1_IN;
  logic [7:0]       DATA_B1_IN;
  logic [1:0]       CH_SEL;
  logic             RD_EN;
  logic [7:0]       RD_ADDR;
  logic [BIN_W-1:0] RD_DATA;
  logic             RD_VALID;
  logic             HIST_READY;
  logic             BUSY;
  logic [BIN_W-1:0] PIXEL_COUNT;
  logic             OVERRUN;
  logic             FRAME_ERR;

  modport master (
    output VSYNC, HSYNC, DATA_R0_IN, DATA_G0_IN, DATA_B0_IN,
           DATA_R1_IN, DATA_G1_IN, DATA_B1_IN, CH_SEL, RD_EN, RD_ADDR,
    input  RD_DATA, RD_VALID, HIST_READY, BUSY, PIXEL_COUNT, OVERRUN, FRAME_ERR
  );

  modport slave (
    input  VSYNC, HSYNC, DATA_R0_IN, DATA_G0_IN, DATA_B0_IN,
           DATA_R1_IN, DATA_G1_IN, DATA_B1_IN, CH_SEL, RD_EN, RD_ADDR,
    output RD_DATA, RD_VALID, HIST_READY, BUSY, PIXEL_COUNT, OVERRUN, FRAME_ERR
  );
endinterface

// File: rtl/frame_histogram.sv
// Per-frame 256-bin histogram of a two-pixel-per-clock RGB stream (luma or one channel),
// frozen after a full frame and read back through a registered one-cycle port.
//
// state    | meaning
// ST_CLEAR | zero one bin per cycle via clr_ptr_q, pixel count held at 0
// ST_ARMED | channel select latched, waiting for the first HSYNC of the frame
// ST_ACCUM | binning pixel pairs (keys registered, array updated one cycle later)
// ST_DONE  | array frozen, read port active, VSYNC rise starts a new frame
module frame_histogram #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int BIN_W  = 20
) (
  input logic              HCLK,
  input logic              HRESETn,
  frame_histogram_if.slave bus
);
  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int PC_W  = (CNT_W > BIN_W) ? CNT_W : BIN_W;
  localparam logic [PC_W-1:0] TOTAL_V   = PC_W'(TOTAL);
  localparam logic [PC_W-1:0] BIN_MAX_V = PC_W'((64'd1 << BIN_W) - 64'd1);

  typedef enum logic [1:0] {ST_CLEAR, ST_ARMED, ST_ACCUM, ST_DONE} state_t;

  state_t           state_q;
  logic [7:0]       clr_ptr_q;
  logic             vsync_q;
  logic [1:0]       ch_sel_q;
  logic [PC_W-1:0]  pix_cnt_q;
  logic             upd_q;
  logic [7:0]       key0_q, key1_q;
  logic [BIN_W-1:0] rd_data_q;
  logic             rd_valid_q;
  logic             overrun_q;
  logic             frame_err_q;
  logic [BIN_W-1:0] bins_q [256];

  logic             vs_rise_d;
  logic             accept_d;
  logic [7:0]       key0_d, key1_d;
  logic [PC_W:0]    committed_d;

  function automatic logic [7:0] pixel_key(input logic [1:0] sel,
                                           input logic [7:0] r, g, b);
    logic [17:0] luma;
    luma = 18'd306 * {10'd0, r} + 18'd601 * {10'd0, g} + 18'd116 * {10'd0, b};
    case (sel)
      2'd0:    pixel_key = luma[17:10];
      2'd1:    pixel_key = r;
      2'd2:    pixel_key = g;
      default: pixel_key = b;
    endcase
  endfunction

  function automatic logic [BIN_W-1:0] sat_add(input logic [BIN_W-1:0] v,
                                               input logic [1:0] inc);
    logic [BIN_W:0] s;
    s = {1'b0, v} + {{(BIN_W-1){1'b0}}, inc};
    sat_add = s[BIN_W] ? {BIN_W{1'b1}} : s[BIN_W-1:0];
  endfunction

  // A pair still in the key stage counts toward the frame so no extra pair slips in.
  always_comb begin
    vs_rise_d   = bus.VSYNC & ~vsync_q;
    key0_d      = pixel_key(ch_sel_q, bus.DATA_R0_IN, bus.DATA_G0_IN, bus.DATA_B0_IN);
    key1_d      = pixel_key(ch_sel_q, bus.DATA_R1_IN, bus.DATA_G1_IN, bus.DATA_B1_IN);
    committed_d = {1'b0, pix_cnt_q} + (upd_q ? (PC_W+1)'(2) : (PC_W+1)'(0));
    accept_d    = bus.HSYNC && (committed_d < {1'b0, TOTAL_V});
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_CLEAR;
      clr_ptr_q   <= '0;
      vsync_q     <= 1'b0;
      ch_sel_q    <= '0;
      pix_cnt_q   <= '0;
      upd_q       <= 1'b0;
      key0_q      <= '0;
      key1_q      <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      vsync_q    <= bus.VSYNC;
      rd_valid_q <= 1'b0;
      upd_q      <= 1'b0;
      if (upd_q) pix_cnt_q <= pix_cnt_q + PC_W'(2);
      case (state_q)
        ST_CLEAR: begin
          clr_ptr_q <= clr_ptr_q + 8'd1;
          if (bus.HSYNC) overrun_q <= 1'b1;
          if (clr_ptr_q == 8'd255) begin
            state_q  <= ST_ARMED;
            ch_sel_q <= bus.CH_SEL;
          end
        end
        ST_ARMED: begin
          if (bus.HSYNC) begin
            key0_q  <= key0_d;
            key1_q  <= key1_d;
            upd_q   <= 1'b1;
            state_q <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (vs_rise_d) begin
            frame_err_q <= 1'b1;
            state_q     <= ST_CLEAR;
            clr_ptr_q   <= '0;
            pix_cnt_q   <= '0;
          end else begin
            if (accept_d) begin
              key0_q <= key0_d;
              key1_q <= key1_d;
              upd_q  <= 1'b1;
            end
            if (pix_cnt_q == TOTAL_V) state_q <= ST_DONE;
          end
        end
        default: begin
          if (bus.RD_EN) begin
            rd_data_q  <= bins_q[bus.RD_ADDR];
            rd_valid_q <= 1'b1;
          end
          if (vs_rise_d) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
            pix_cnt_q <= '0;
          end
        end
      endcase
    end
  end

  // Bins are left untouched by reset; ST_CLEAR re-zeroes them.
  always_ff @(posedge HCLK) begin
    if (state_q == ST_CLEAR) begin
      bins_q[clr_ptr_q] <= '0;
    end else if (upd_q) begin
      if (key0_q == key1_q) begin
        bins_q[key0_q] <= sat_add(bins_q[key0_q], 2'd2);
      end else begin
        bins_q[key0_q] <= sat_add(bins_q[key0_q], 2'd1);
        bins_q[key1_q] <= sat_add(bins_q[key1_q], 2'd1);
      end
    end
  end

  assign bus.RD_DATA     = rd_data_q;
  assign bus.RD_VALID    = rd_valid_q;
  assign bus.HIST_READY  = (state_q == ST_DONE);
  assign bus.BUSY        = (state_q == ST_CLEAR) || (state_q == ST_ACCUM);
  assign bus.PIXEL_COUNT = (pix_cnt_q > BIN_MAX_V) ? BIN_MAX_V[BIN_W-1:0]
                                                   : pix_cnt_q[BIN_W-1:0];
  assign bus.OVERRUN     = overrun_q;
  assign bus.FRAME_ERR   = frame_err_q;
endmodule

// File: tb/tb_frame_histogram.sv
// Bench for frame_histogram: a wide-counter instance and a 4-bit saturating instance
// share one stimulus stream; bin reads are scoreboarded against a reference histogram.
module tb_frame_histogram;
  localparam int W     = 8;
  localparam int H     = 4;
  localparam int PAIRS = W * H / 2;
  localparam int MAX_A = (1 << 20) - 1;
  localparam int MAX_B = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frame_histogram_if #(.BIN_W(20)) ha();
  frame_histogram_if #(.BIN_W(4))  hb();

  assign hb.VSYNC      = ha.VSYNC;
  assign hb.HSYNC      = ha.HSYNC;
  assign hb.DATA_R0_IN = ha.DATA_R0_IN;
  assign hb.DATA_G0_IN = ha.DATA_G0_IN;
  assign hb.DATA_B0_IN = ha.DATA_B0_IN;
  assign hb.DATA_R1_IN = ha.DATA_R1_IN;
  assign hb.DATA_G1_IN = ha.DATA_G1_IN;
  assign hb.DATA_B1_IN = ha.DATA_B1_IN;
  assign hb.CH_SEL     = ha.CH_SEL;
  assign hb.RD_EN      = ha.RD_EN;
  assign hb.RD_ADDR    = ha.RD_ADDR;

  frame_histogram #(.WIDTH(W), .HEIGHT(H), .BIN_W(20)) dut_a (
    .HCLK(clk), .HRESETn(rst_n), .bus(ha)
  );
  frame_histogram #(.WIDTH(W), .HEIGHT(H), .BIN_W(4)) dut_b (
    .HCLK(clk), .HRESETn(rst_n), .bus(hb)
  );

  typedef struct {
    int addr;
    int exp;
    int cyc;
  } rd_t;

  rd_t qa[$];
  rd_t qb[$];
  int  model_a [256];
  int  model_b [256];
  int  errors = 0;
  int  checks = 0;
  int  cyc    = 0;
  int  sel    = 0;
  int  last_a = 0;
  int  last_b = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Each read must come back exactly one cycle after its request.
  always @(negedge clk) begin
    rd_t e;
    if (qa.size() > 0 && qa[0].cyc + 1 == cyc) begin
      e = qa.pop_front();
      check($sformatf("rd_a_valid[%0d]", e.addr), 32'(ha.RD_VALID), 1);
      check($sformatf("rd_a_data[%0d]", e.addr), 32'(ha.RD_DATA), e.exp);
    end else if (ha.RD_VALID !== 1'b0) begin
      check("rd_a_spurious_valid", 32'(ha.RD_VALID), 0);
    end
    if (qb.size() > 0 && qb[0].cyc + 1 == cyc) begin
      e = qb.pop_front();
      check($sformatf("rd_b_valid[%0d]", e.addr), 32'(hb.RD_VALID), 1);
      check($sformatf("rd_b_data[%0d]", e.addr), 32'(hb.RD_DATA), e.exp);
    end else if (hb.RD_VALID !== 1'b0) begin
      check("rd_b_spurious_valid", 32'(hb.RD_VALID), 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic int bkey(input int s, input int r, input int g, input int b);
    case (s)
      0:       return (306 * r + 601 * g + 116 * b) / 1024;
      1:       return r;
      2:       return g;
      default: return b;
    endcase
  endfunction

  task automatic clear_models();
    for (int i = 0; i < 256; i++) begin
      model_a[i] = 0;
      model_b[i] = 0;
    end
  endtask

  task automatic bump(input int k);
    if (model_a[k] < MAX_A) model_a[k]++;
    if (model_b[k] < MAX_B) model_b[k]++;
  endtask

  task automatic drive_pair(input int r0, input int g0, input int b0,
                            input int r1, input int g1, input int b1, input bit count);
    ha.HSYNC      = 1'b1;
    ha.DATA_R0_IN = 8'(r0);
    ha.DATA_G0_IN = 8'(g0);
    ha.DATA_B0_IN = 8'(b0);
    ha.DATA_R1_IN = 8'(r1);
    ha.DATA_G1_IN = 8'(g1);
    ha.DATA_B1_IN = 8'(b1);
    if (count) begin
      bump(bkey(sel, r0, g0, b0));
      bump(bkey(sel, r1, g1, b1));
    end
    tick();
  endtask

  task automatic rand_pair(input bit count);
    drive_pair($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), count);
  endtask

  // pat 0: flat grey 100, 1: collision pairs, 2: flat 7, 3: random
  task automatic send_frame(input int pat);
    for (int i = 0; i < PAIRS; i++) begin
      case (pat)
        0: drive_pair(100, 100, 100, 100, 100, 100, 1'b1);
        1: begin
          if (i == 0)      drive_pair(5, 3 * i, 3 * i, 5, 3 * i, 3 * i, 1'b1);
          else if (i == 1) drive_pair(5, 3 * i, 3 * i, 6, 3 * i, 3 * i, 1'b1);
          else             drive_pair(20 + i, 3 * i, 3 * i, 60 + i, 3 * i, 3 * i, 1'b1);
        end
        2: drive_pair(7, 7, 7, 7, 7, 7, 1'b1);
        default: rand_pair(1'b1);
      endcase
    end
    ha.HSYNC = 1'b0;
    tick();
    check("ready_early", 32'(ha.HIST_READY), 0);
    tick();
    check("hist_ready", 32'(ha.HIST_READY), 1);
    check("busy_done", 32'(ha.BUSY), 0);
    check("pixel_count", 32'(ha.PIXEL_COUNT), W * H);
  endtask

  // Read order ends on bin 99 so the held-value check after it is non-trivial.
  task automatic read_all();
    int a;
    for (int i = 0; i < 256; i++) begin
      a = (i + 100) % 256;
      ha.RD_EN   = 1'b1;
      ha.RD_ADDR = 8'(a);
      qa.push_back('{a, model_a[a], cyc});
      qb.push_back('{a, model_b[a], cyc});
      tick();
    end
    ha.RD_EN = 1'b0;
    last_a   = model_a[99];
    last_b   = model_b[99];
    ticks(2);
    check("rd_a_drain", 32'(qa.size()), 0);
    check("rd_b_drain", 32'(qb.size()), 0);
  endtask

  task automatic start_frame(input int s);
    sel       = s;
    ha.CH_SEL = 2'(s);
    ha.VSYNC  = 1'b1;
    ticks(2);
    ha.VSYNC  = 1'b0;
    ticks(270);
    clear_models();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rd_data"},   32'(ha.RD_DATA), 0);
    check({tag, "_rd_valid"},  32'(ha.RD_VALID), 0);
    check({tag, "_ready"},     32'(ha.HIST_READY), 0);
    check({tag, "_busy"},      32'(ha.BUSY), 1);
    check({tag, "_pixcnt"},    32'(ha.PIXEL_COUNT), 0);
    check({tag, "_overrun"},   32'(ha.OVERRUN), 0);
    check({tag, "_frame_err"}, 32'(ha.FRAME_ERR), 0);
    check({tag, "_b_busy"},    32'(hb.BUSY), 1);
    check({tag, "_b_rd_data"}, 32'(hb.RD_DATA), 0);
  endtask

  initial begin
    ha.VSYNC = 1'b0;  ha.HSYNC = 1'b0;
    ha.DATA_R0_IN = '0; ha.DATA_G0_IN = '0; ha.DATA_B0_IN = '0;
    ha.DATA_R1_IN = '0; ha.DATA_G1_IN = '0; ha.DATA_B1_IN = '0;
    ha.CH_SEL = 2'd0; ha.RD_EN = 1'b0; ha.RD_ADDR = '0;
    ticks(3);
    check_reset_values("reset");
    rst_n = 1'b1;
    sel   = 0;
    ticks(270);
    clear_models();
    check("armed_busy", 32'(ha.BUSY), 0);
    check("armed_ready", 32'(ha.HIST_READY), 0);

    // Flat grey frame, then HSYNC while frozen must not disturb anything
    send_frame(0);
    for (int i = 0; i < 3; i++) drive_pair(200, 10, 30, 40, 50, 60, 1'b0);
    ha.HSYNC = 1'b0;
    tick();
    check("done_pixcnt_frozen", 32'(ha.PIXEL_COUNT), W * H);
    check("done_ready_held", 32'(ha.HIST_READY), 1);
    read_all();

    // Read requests while clearing are refused and RD_DATA holds
    sel       = 1;
    ha.CH_SEL = 2'd1;
    ha.VSYNC  = 1'b1;
    tick();
    check("clear_busy", 32'(ha.BUSY), 1);
    check("clear_ready", 32'(ha.HIST_READY), 0);
    check("clear_pixcnt", 32'(ha.PIXEL_COUNT), 0);
    ha.VSYNC   = 1'b0;
    ha.RD_EN   = 1'b1;
    ha.RD_ADDR = 8'd7;
    ticks(2);
    check("busy_rd_valid", 32'(ha.RD_VALID), 0);
    check("busy_rd_hold_a", 32'(ha.RD_DATA), last_a);
    check("busy_rd_hold_b", 32'(hb.RD_DATA), last_b);
    ha.RD_EN = 1'b0;
    ticks(270);
    clear_models();

    // Red channel with same-key and split-key pairs
    send_frame(1);
    read_all();

    // Flat 7 on green: the 4-bit instance must clamp at 15
    start_frame(2);
    send_frame(2);
    read_all();

    // VSYNC mid-frame aborts and the next frame carries no residue
    start_frame(3);
    for (int i = 0; i < 6; i++) rand_pair(1'b0);
    ha.HSYNC = 1'b0;
    ha.VSYNC = 1'b1;
    tick();
    check("abort_frame_err", 32'(ha.FRAME_ERR), 1);
    check("abort_busy", 32'(ha.BUSY), 1);
    check("abort_pixcnt", 32'(ha.PIXEL_COUNT), 0);
    ha.VSYNC = 1'b0;
    ticks(270);
    clear_models();
    send_frame(3);
    read_all();

    // HSYNC 50 cycles after VSYNC rise lands in the clear and is dropped
    sel       = 2;
    ha.CH_SEL = 2'd2;
    ha.VSYNC  = 1'b1;
    tick();
    ha.VSYNC  = 1'b0;
    ticks(49);
    for (int i = 0; i < 4; i++) rand_pair(1'b0);
    ha.HSYNC = 1'b0;
    tick();
    check("overrun_set", 32'(ha.OVERRUN), 1);
    check("overrun_busy", 32'(ha.BUSY), 1);
    check("overrun_pixcnt", 32'(ha.PIXEL_COUNT), 0);
    ticks(250);
    clear_models();
    check("overrun_armed_pixcnt", 32'(ha.PIXEL_COUNT), 0);
    send_frame(3);
    check("overrun_sticky", 32'(ha.OVERRUN), 1);
    check("frame_err_sticky", 32'(ha.FRAME_ERR), 1);
    read_all();

    // Asynchronous reset in the middle of accumulation
    start_frame(0);
    for (int i = 0; i < 5; i++) rand_pair(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    ha.HSYNC = 1'b0;
    tick();
    rst_n = 1'b1;
    ticks(270);
    clear_models();
    send_frame(3);
    read_all();

    ticks(3);
    check("final_qa_empty", 32'(qa.size()), 0);
    check("final_qb_empty", 32'(qb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
